// File: rtl/enigma_pkg.sv
// Shared rotor definitions: position range, position width and engine FSM states.
// Used by both the forward-stepping and the rewind engines.
package enigma_pkg;

  localparam int NUM_POS = 26;
  localparam int POS_W   = 6;

  typedef logic [POS_W-1:0] pos_t;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    REWIND = 1'b1
  } eng_state_t;

  // Out-of-range load values fall back to position 0 so a rotor is never illegal.
  function automatic pos_t load_fix(input pos_t p, input int unsigned num_pos);
    if (32'(p) >= num_pos) begin
      return {POS_W{1'b0}};
    end else begin
      return p;
    end
  endfunction

endpackage

// File: rtl/rotor_dec.sv
// One rotor of the reverse-step chain: decrement on borrow_in, wrap 0 -> NUM_POS-1
// and pass the borrow on to the next rotor.
module rotor_dec
  import enigma_pkg::*;
#(
  parameter int NUM_POS = enigma_pkg::NUM_POS
) (
  input  logic [POS_W-1:0] pos,
  input  logic             borrow_in,
  output logic [POS_W-1:0] pos_next,
  output logic             borrow_out
);

  logic at_zero;

  assign at_zero    = (pos == {POS_W{1'b0}});
  assign borrow_out = borrow_in & at_zero;

  // Next position for this rotor given the incoming borrow.
  always_comb begin
    pos_next = pos;
    if (!borrow_in) begin
      pos_next = pos;
    end else if (at_zero) begin
      pos_next = POS_W'(NUM_POS - 1);
    end else begin
      pos_next = pos - POS_W'(1);
    end
  end

endmodule

// File: rtl/rotor_rewind_engine.sv
// Reverse-stepping rotor engine: one step per accepted character, or a bulk
// rewind of rewind_count steps at one step per cycle.
module rotor_rewind_engine
  import enigma_pkg::*;
#(
  parameter int NUM_POS = enigma_pkg::NUM_POS,
  parameter int CNT_W   = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_en,
  input  logic [5:0]       load_pos1,
  input  logic [5:0]       load_pos2,
  input  logic [5:0]       load_pos3,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       char_in,
  output logic             out_valid,
  output logic [5:0]       char_out,
  output logic [5:0]       rotor1_pos,
  output logic [5:0]       rotor2_pos,
  output logic [5:0]       rotor3_pos,
  input  logic             rewind_start,
  input  logic [CNT_W-1:0] rewind_count,
  output logic             busy,
  output logic             done
);

  eng_state_t       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             do_step, do_load, accept, done_next;
  pos_t             r1_dec, r2_dec, r3_dec;
  logic             b1, b2, b3_unused;

  rotor_dec #(.NUM_POS(NUM_POS)) u_dec1 (
    .pos(rotor1_pos), .borrow_in(1'b1), .pos_next(r1_dec), .borrow_out(b1)
  );
  rotor_dec #(.NUM_POS(NUM_POS)) u_dec2 (
    .pos(rotor2_pos), .borrow_in(b1), .pos_next(r2_dec), .borrow_out(b2)
  );
  rotor_dec #(.NUM_POS(NUM_POS)) u_dec3 (
    .pos(rotor3_pos), .borrow_in(b2), .pos_next(r3_dec), .borrow_out(b3_unused)
  );

  assign in_ready = (state == IDLE);
  assign busy     = (state == REWIND);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Arbitration (load > rewind_start > in_valid) and next-state decode.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    do_step    = 1'b0;
    do_load    = 1'b0;
    accept     = 1'b0;
    done_next  = 1'b0;
    if (load_en) begin
      do_load    = 1'b1;
      state_next = IDLE;
      cnt_next   = {CNT_W{1'b0}};
    end else begin
      case (state)
        IDLE: begin
          if (rewind_start) begin
            if (rewind_count == {CNT_W{1'b0}}) begin
              done_next = 1'b1;
            end else begin
              state_next = REWIND;
              cnt_next   = rewind_count;
            end
          end else if (in_valid) begin
            accept  = 1'b1;
            do_step = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
        REWIND: begin
          do_step = 1'b1;
          // A zero count here can only come from corruption; leave cleanly anyway.
          if (cnt <= CNT_W'(1)) begin
            state_next = IDLE;
            cnt_next   = {CNT_W{1'b0}};
            done_next  = 1'b1;
          end else begin
            state_next = REWIND;
            cnt_next   = cnt - CNT_W'(1);
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Datapath registers: rotor positions, counter and the output strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rotor1_pos <= 6'd0;
      rotor2_pos <= 6'd0;
      rotor3_pos <= 6'd0;
      char_out   <= 6'd0;
      out_valid  <= 1'b0;
      done       <= 1'b0;
      cnt        <= {CNT_W{1'b0}};
    end else begin
      cnt       <= cnt_next;
      done      <= done_next;
      out_valid <= accept;
      if (accept) begin
        char_out <= char_in;
      end else begin
        char_out <= char_out;
      end
      if (do_load) begin
        rotor1_pos <= load_fix(load_pos1, NUM_POS);
        rotor2_pos <= load_fix(load_pos2, NUM_POS);
        rotor3_pos <= load_fix(load_pos3, NUM_POS);
      end else if (do_step) begin
        rotor1_pos <= r1_dec;
        rotor2_pos <= r2_dec;
        rotor3_pos <= r3_dec;
      end else begin
        rotor1_pos <= rotor1_pos;
        rotor2_pos <= rotor2_pos;
        rotor3_pos <= rotor3_pos;
      end
    end
  end

endmodule

// File: tb/tb_rotor_rewind_engine.sv
// Self-checking bench for rotor_rewind_engine: directed scenarios plus random traffic
// against a model that treats the three rotors as one base-NUM_POS number.
module tb_rotor_rewind_engine;

  localparam int NUM_POS = 26;
  localparam int CNT_W   = 10;
  localparam int SPAN    = NUM_POS * NUM_POS * NUM_POS;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             load_en = 1'b0;
  logic [5:0]       load_pos1 = 6'd0, load_pos2 = 6'd0, load_pos3 = 6'd0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [5:0]       char_in = 6'd0;
  logic             out_valid;
  logic [5:0]       char_out;
  logic [5:0]       rotor1_pos, rotor2_pos, rotor3_pos;
  logic             rewind_start = 1'b0;
  logic [CNT_W-1:0] rewind_count = '0;
  logic             busy, done;
  logic [17:0]      dpos;

  int checks = 0;
  int failures = 0;
  int model = 0;
  logic [5:0] last_char = 6'd0;

  rotor_rewind_engine #(.NUM_POS(NUM_POS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .load_en(load_en),
    .load_pos1(load_pos1), .load_pos2(load_pos2), .load_pos3(load_pos3),
    .in_valid(in_valid), .in_ready(in_ready), .char_in(char_in),
    .out_valid(out_valid), .char_out(char_out),
    .rotor1_pos(rotor1_pos), .rotor2_pos(rotor2_pos), .rotor3_pos(rotor3_pos),
    .rewind_start(rewind_start), .rewind_count(rewind_count),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  assign dpos = {rotor3_pos, rotor2_pos, rotor1_pos};

  function automatic logic [17:0] pv(input int m);
    return {6'(m / (NUM_POS * NUM_POS)), 6'((m / NUM_POS) % NUM_POS), 6'(m % NUM_POS)};
  endfunction

  function automatic int lin(input int a, input int b, input int c);
    int fa = (a >= NUM_POS) ? 0 : a;
    int fb = (b >= NUM_POS) ? 0 : b;
    int fc = (c >= NUM_POS) ? 0 : c;
    return fa + NUM_POS * fb + NUM_POS * NUM_POS * fc;
  endfunction

  function automatic int rev(input int m, input int k);
    return (((m - k) % SPAN) + SPAN) % SPAN;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int a, input int b, input int c);
    load_en = 1'b1;
    load_pos1 = 6'(a); load_pos2 = 6'(b); load_pos3 = 6'(c);
    tick();
    load_en = 1'b0;
    model = lin(a, b, c);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({out_valid, busy, done, char_out, dpos} !== 27'd0) begin
      failures++;
      $display("FAIL reset_outputs: got ov=%b busy=%b done=%b char=%0d pos=%h want all 0",
               out_valid, busy, done, char_out, dpos);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    #2 rst_n = 1'b1;
    tick();
    model = 0;
    checks++;
    if (in_ready !== 1'b1 || dpos !== 18'd0) begin
      failures++;
      $display("FAIL reset_release: got rdy=%b pos=%h want 1/0", in_ready, dpos);
    end
  endtask

  task automatic test_single_char();
    in_valid = 1'b1; char_in = 6'd3;
    tick();
    in_valid = 1'b0;
    model = rev(model, 1);
    last_char = 6'd3;
    checks++;
    if (out_valid !== 1'b1 || char_out !== 6'd3 || dpos !== pv(model)
        || dpos !== {6'd25, 6'd25, 6'd25}) begin
      failures++;
      $display("FAIL single_char: got ov=%b char=%0d pos=%h want 1/3/%h", out_valid, char_out, dpos, pv(model));
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_char_pulse: got ov=%b want 0", out_valid);
    end
  endtask

  task automatic test_borrow_char();
    do_load(0, 1, 0);
    in_valid = 1'b1; char_in = 6'd17;
    tick();
    in_valid = 1'b0;
    model = rev(model, 1);
    last_char = 6'd17;
    checks++;
    if (out_valid !== 1'b1 || dpos !== pv(model) || dpos !== {6'd0, 6'd0, 6'd25}) begin
      failures++;
      $display("FAIL borrow_char: got ov=%b pos=%h want 1/%h", out_valid, dpos, pv(model));
    end
  endtask

  task automatic test_load_range();
    do_load(26, 25, 63);
    checks++;
    if (dpos !== pv(model) || dpos !== {6'd0, 6'd25, 6'd0}) begin
      failures++;
      $display("FAIL load_range: got pos=%h want %h", dpos, pv(model));
    end
  endtask

  task automatic test_rewind();
    int busy_cycles = 0;
    do_load(5, 5, 5);
    rewind_start = 1'b1; rewind_count = CNT_W'(7);
    tick();
    rewind_start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (busy === 1'b1) busy_cycles++;
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
        failures++;
        $display("FAIL rewind_busy[%0d]: got busy=%b rdy=%b ov=%b done=%b want 1/0/0/0",
                 i, busy, in_ready, out_valid, done);
      end
      in_valid = 1'b1; char_in = 6'd9;
      rewind_start = (i == 2);
      rewind_count = CNT_W'(3);
      tick();
    end
    in_valid = 1'b0; rewind_start = 1'b0;
    model = rev(model, 7);
    checks++;
    if (busy !== 1'b0 || done !== 1'b1 || out_valid !== 1'b0 || dpos !== pv(model)
        || dpos !== {6'd5, 6'd4, 6'd24} || busy_cycles != 7) begin
      failures++;
      $display("FAIL rewind_done: got busy=%b done=%b ov=%b pos=%h cycles=%0d want 0/1/0/%h/7",
               busy, done, out_valid, dpos, busy_cycles, pv(model));
    end
    tick();
    checks++;
    if (done !== 1'b0 || dpos !== pv(model) || char_out !== last_char) begin
      failures++;
      $display("FAIL rewind_after: got done=%b pos=%h char=%0d want 0/%h/%0d", done, dpos, char_out, pv(model), last_char);
    end
  endtask

  task automatic test_rewind_zero();
    rewind_start = 1'b1; rewind_count = '0;
    tick();
    rewind_start = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1 || dpos !== pv(model)) begin
      failures++;
      $display("FAIL rewind_zero: got done=%b busy=%b rdy=%b pos=%h want 1/0/1/%h", done, busy, in_ready, dpos, pv(model));
    end
    tick();
    checks++;
    if (done !== 1'b0 || dpos !== pv(model)) begin
      failures++;
      $display("FAIL rewind_zero_pulse: got done=%b pos=%h want 0/%h", done, dpos, pv(model));
    end
  endtask

  task automatic test_load_abort();
    do_load(2, 0, 0);
    rewind_start = 1'b1; rewind_count = CNT_W'(10);
    tick();
    rewind_start = 1'b0;
    tick();
    tick();
    do_load(9, 9, 9);
    checks++;
    if (dpos !== pv(model) || busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL load_abort: got pos=%h busy=%b done=%b rdy=%b want %h/0/0/1", dpos, busy, done, in_ready, pv(model));
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (done !== 1'b0 || dpos !== pv(model)) begin
        failures++;
        $display("FAIL load_abort_quiet[%0d]: got done=%b pos=%h want 0/%h", i, done, dpos, pv(model));
      end
    end
  endtask

  task automatic test_reset_mid_rewind();
    in_valid = 1'b1; char_in = 6'h2A;
    tick();
    in_valid = 1'b0;
    rewind_start = 1'b1; rewind_count = CNT_W'(20);
    tick();
    rewind_start = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, busy, done, char_out, dpos} !== 27'd0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_rewind: got ov=%b busy=%b done=%b char=%0d pos=%h rdy=%b want 0s, rdy=1",
               out_valid, busy, done, char_out, dpos, in_ready);
    end
    #1 rst_n = 1'b1;
    model = 0;
    last_char = 6'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || dpos !== 18'd0) begin
        failures++;
        $display("FAIL reset_release_mid[%0d]: got rdy=%b busy=%b done=%b pos=%h want 1/0/0/0", i, in_ready, busy, done, dpos);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] c;
    do_load(int'($urandom_range(25)), int'($urandom_range(25)), int'($urandom_range(25)));
    for (int i = 0; i < 40; i++) begin
      c = 6'($urandom_range(63));
      in_valid = 1'b1; char_in = c;
      tick();
      model = rev(model, 1);
      last_char = c;
      checks++;
      if (out_valid !== 1'b1 || char_out !== c || dpos !== pv(model)) begin
        failures++;
        $display("FAIL back_to_back[%0d]: got ov=%b char=%0d pos=%h want 1/%0d/%h", i, out_valid, char_out, dpos, c, pv(model));
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || dpos !== pv(model)) begin
      failures++;
      $display("FAIL back_to_back_end: got ov=%b pos=%h want 0/%h", out_valid, dpos, pv(model));
    end
  endtask

  task automatic test_random_mixed();
    int rem = 0;
    logic ld, rs, iv, exp_ov, exp_done;
    int a, b, c, cnt;
    logic [5:0] ch;
    for (int i = 0; i < 400; i++) begin
      ld = ($urandom_range(15) == 0);
      rs = ($urandom_range(7) == 0);
      iv = $urandom_range(1) == 1;
      a = int'($urandom_range(63)); b = int'($urandom_range(63)); c = int'($urandom_range(63));
      cnt = int'($urandom_range(5));
      ch = 6'($urandom_range(63));
      load_en = ld; load_pos1 = 6'(a); load_pos2 = 6'(b); load_pos3 = 6'(c);
      rewind_start = rs; rewind_count = CNT_W'(cnt);
      in_valid = iv; char_in = ch;
      tick();
      exp_ov = 1'b0; exp_done = 1'b0;
      if (ld) begin
        model = lin(a, b, c); rem = 0;
      end else if (rem > 0) begin
        model = rev(model, 1); rem--;
        exp_done = (rem == 0);
      end else if (rs) begin
        if (cnt == 0) exp_done = 1'b1;
        else rem = cnt;
      end else if (iv) begin
        model = rev(model, 1); exp_ov = 1'b1; last_char = ch;
      end
      checks++;
      if (dpos !== pv(model) || out_valid !== exp_ov || done !== exp_done || char_out !== last_char
          || busy !== (rem > 0) || in_ready !== (rem == 0)) begin
        failures++;
        $display("FAIL random[%0d]: got pos=%h ov=%b done=%b char=%0d busy=%b rdy=%b want %h/%b/%b/%0d/%b/%b",
                 i, dpos, out_valid, done, char_out, busy, in_ready,
                 pv(model), exp_ov, exp_done, last_char, rem > 0, rem == 0);
      end
    end
    load_en = 1'b0; rewind_start = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_char();
    test_borrow_char();
    test_load_range();
    test_rewind();
    test_rewind_zero();
    test_load_abort();
    test_reset_mid_rewind();
    test_back_to_back();
    test_random_mixed();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
